// File: rtl/trace_pkg.sv
// trace_pkg: shared state encodings for the trace flush controller.
package trace_pkg;
    typedef enum logic [1:0] {FREE, FULL, DRAINING} bank_state_e;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} drain_state_e;
endpackage

// File: rtl/trace_drain_fsm.sv
// trace_drain_fsm: issues one engine command per sealed bank and waits for its completion.
module trace_drain_fsm
    import trace_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic bank_full,
    input  logic eng_start_ready,
    input  logic eng_done_valid,
    output logic eng_start_valid,
    output logic eng_done_ready,
    output logic launch,
    output logic done
);
    drain_state_e state_q, state_d;
    logic start_valid_q, start_valid_d, done_ready_q, done_ready_d;

    assign launch = state_q == IDLE && bank_full;
    assign done = state_q == WAIT_DONE && eng_done_valid;
    assign eng_start_valid = start_valid_q;
    assign eng_done_ready = done_ready_q;

    always_comb begin
        state_d = state_q;
        if (launch)
            state_d = ISSUE;
        else if (state_q == ISSUE && eng_start_ready)
            state_d = WAIT_DONE;
        else if (done)
            state_d = IDLE;
        start_valid_d = state_d == ISSUE;
        done_ready_d = state_d == WAIT_DONE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            start_valid_q <= 1'b0;
            done_ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            start_valid_q <= start_valid_d;
            done_ready_q <= done_ready_d;
        end
    end
endmodule

// File: rtl/trace_flush_controller.sv
// trace_flush_controller: double-buffers a trace stream into two banks and hands
// sealed banks to a burst-write engine that copies them into a circular AXI region.
module trace_flush_controller
    import trace_pkg::*;
#(
    parameter int BufferAddrWidth = 8,
    parameter int DataWidth = 32,
    parameter int AXIAddrWidth = 32,
    parameter int RegionWords = 1024
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       trace_valid,
    output logic                       trace_ready,
    input  logic [DataWidth-1:0]       trace_data,
    input  logic                       flush,
    input  logic [AXIAddrWidth-1:0]    axi_base,
    output logic                       buf_ce,
    output logic                       buf_we,
    output logic [BufferAddrWidth-1:0] buf_addr,
    output logic [DataWidth-1:0]       buf_wdata,
    output logic                       eng_start_valid,
    input  logic                       eng_start_ready,
    output logic [BufferAddrWidth-1:0] eng_data_ptr,
    output logic [BufferAddrWidth-1:0] eng_data_size,
    output logic [AXIAddrWidth-1:0]    eng_axi_offset,
    input  logic                       eng_done_valid,
    output logic                       eng_done_ready,
    output logic [15:0]                flush_count
);
    localparam int CntW = BufferAddrWidth - 1;
    localparam int BankWords = 2 ** CntW;
    localparam int WordW = $clog2(RegionWords) + 2;
    localparam int WordBytes = DataWidth / 8;

    bank_state_e bank_q [2], bank_d [2];
    logic [BufferAddrWidth-1:0] size_q [2], size_d [2];
    logic fill_bank_q, fill_bank_d, drain_bank_q, drain_bank_d;
    logic [CntW-1:0] fill_count_q, fill_count_d;
    logic [WordW-1:0] wr_word_q, wr_word_d, burst_word_q, burst_word_d, eff_word;
    logic buf_we_q, buf_we_d;
    logic [BufferAddrWidth-1:0] buf_addr_q, buf_addr_d, ptr_q, ptr_d, dsize_q, dsize_d;
    logic [DataWidth-1:0] buf_wdata_q, buf_wdata_d;
    logic [AXIAddrWidth-1:0] offset_q, offset_d;
    logic [15:0] flush_count_q, flush_count_d;
    logic [BufferAddrWidth-1:0] count_next;
    logic hs, seal, bank_full, launch, done;

    assign trace_ready = !reset && bank_q[fill_bank_q] == FREE;
    assign hs = trace_valid && trace_ready;
    // A word arriving alongside flush is counted before the bank is sealed.
    assign count_next = {1'b0, fill_count_q} + BufferAddrWidth'(hs);
    assign seal = (hs && fill_count_q == CntW'(BankWords - 1)) || (flush && count_next != '0);
    assign bank_full = bank_q[drain_bank_q] == FULL;
    // A burst that would run past the region end restarts at the region base.
    assign eff_word = (wr_word_q + WordW'(size_q[drain_bank_q]) > WordW'(RegionWords)) ? '0 : wr_word_q;

    assign buf_ce = buf_we_q;
    assign buf_we = buf_we_q;
    assign buf_addr = buf_addr_q;
    assign buf_wdata = buf_wdata_q;
    assign eng_data_ptr = ptr_q;
    assign eng_data_size = dsize_q;
    assign eng_axi_offset = offset_q;
    assign flush_count = flush_count_q;

    trace_drain_fsm u_drain (
        .clk             (clk),
        .reset           (reset),
        .bank_full       (bank_full),
        .eng_start_ready (eng_start_ready),
        .eng_done_valid  (eng_done_valid),
        .eng_start_valid (eng_start_valid),
        .eng_done_ready  (eng_done_ready),
        .launch          (launch),
        .done            (done)
    );

    always_comb begin
        bank_d = bank_q;
        size_d = size_q;
        fill_count_d = seal ? '0 : count_next[CntW-1:0];
        fill_bank_d = fill_bank_q ^ seal;
        buf_we_d = hs;
        buf_addr_d = hs ? {fill_bank_q, fill_count_q} : buf_addr_q;
        buf_wdata_d = hs ? trace_data : buf_wdata_q;
        drain_bank_d = drain_bank_q ^ done;
        ptr_d = launch ? {drain_bank_q, CntW'(0)} : ptr_q;
        dsize_d = launch ? size_q[drain_bank_q] : dsize_q;
        burst_word_d = launch ? eff_word : burst_word_q;
        offset_d = launch ? axi_base + AXIAddrWidth'(eff_word) * AXIAddrWidth'(WordBytes) : offset_q;
        wr_word_d = done ? burst_word_q + WordW'(dsize_q) : wr_word_q;
        flush_count_d = flush_count_q + 16'(done);
        if (seal) begin
            bank_d[fill_bank_q] = FULL;
            size_d[fill_bank_q] = count_next;
        end
        if (launch)
            bank_d[drain_bank_q] = DRAINING;
        if (done)
            bank_d[drain_bank_q] = FREE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bank_q[0] <= FREE;
            bank_q[1] <= FREE;
            size_q[0] <= '0;
            size_q[1] <= '0;
            fill_bank_q <= 1'b0;
            fill_count_q <= '0;
            drain_bank_q <= 1'b0;
            wr_word_q <= '0;
            burst_word_q <= '0;
            buf_we_q <= 1'b0;
            buf_addr_q <= '0;
            buf_wdata_q <= '0;
            ptr_q <= '0;
            dsize_q <= '0;
            offset_q <= '0;
            flush_count_q <= '0;
        end else begin
            bank_q <= bank_d;
            size_q <= size_d;
            fill_bank_q <= fill_bank_d;
            fill_count_q <= fill_count_d;
            drain_bank_q <= drain_bank_d;
            wr_word_q <= wr_word_d;
            burst_word_q <= burst_word_d;
            buf_we_q <= buf_we_d;
            buf_addr_q <= buf_addr_d;
            buf_wdata_q <= buf_wdata_d;
            ptr_q <= ptr_d;
            dsize_q <= dsize_d;
            offset_q <= offset_d;
            flush_count_q <= flush_count_d;
        end
    end
endmodule
